// File: rtl/page_stream_queue.sv
// page_stream_queue: circular token queue carrying {eos, data}.
// After an end-of-stream token is accepted, the stream closes. While it is
// closed, new tokens are refused. The stream reopens when that EOS token
// leaves the head of the queue.
//
// Handshake semantics (both sides use the TDF valid/backpressure form):
//   producer side: a token is offered when in_v=1. It is accepted when the
//     stream is open and there is room, or the queue is full but dequeues the
//     same cycle. in_b is advisory only. The producer may send up to SLACK
//     further tokens after it first sees in_b=1.
//   consumer side: a token is transferred on a rising edge where out_v=1 and
//     out_b=0. out_v/out_d/out_e depend only on registers.
module page_stream_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int SLACK = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in_d,
    input  logic                       in_e,
    input  logic                       in_v,
    output logic                       in_b,
    output logic [WIDTH-1:0]           out_d,
    output logic                       out_e,
    output logic                       out_v,
    input  logic                       out_b,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       eos_err,
    output logic                       dbg_state
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] BP_THRESH = CW'(DEPTH - SLACK);

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_CLOSED = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH:0]   r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_eos_err;

    logic             w_deq;
    logic             w_enq;
    logic             w_ovf_set;
    logic             w_eos_set;
    logic [WIDTH:0]   w_head;

    // Head entry and status outputs come from registers only.
    assign w_head    = r_mem[r_rd_ptr];
    assign out_v     = (r_count != '0);
    assign out_d     = w_head[WIDTH-1:0];
    assign out_e     = w_head[WIDTH];
    assign in_b      = (r_state == ST_CLOSED) || (r_count >= BP_THRESH);
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign eos_err   = r_eos_err;
    assign dbg_state = (r_state == ST_CLOSED);

    // Next state and the per-cycle enqueue/dequeue/error decisions.
    // The state at the start of the cycle governs the whole cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_enq       = 1'b0;
        w_ovf_set   = 1'b0;
        w_eos_set   = 1'b0;
        w_deq       = out_v && !out_b;
        case (r_state)
            ST_OPEN: begin
                if (in_v) begin
                    if ((r_count != FULL_CNT) || w_deq) begin
                        w_enq = 1'b1;
                        if (in_e) begin
                            w_state_nxt = ST_CLOSED;
                        end
                    end else begin
                        w_ovf_set = 1'b1;
                    end
                end
            end
            ST_CLOSED: begin
                if (in_v) begin
                    w_eos_set = 1'b1;
                end
                if (w_deq && out_e) begin
                    w_state_nxt = ST_OPEN;
                end
            end
            default: w_state_nxt = ST_OPEN;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_OPEN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_eos_err  <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
            if (w_eos_set) begin
                r_eos_err <= 1'b1;
            end
        end
    end

    // Token storage. Reset clears only entry 0, which becomes the head, so
    // the head reads as zero after reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_mem[0] <= '0;
        end else if (w_enq) begin
            r_mem[r_wr_ptr] <= {in_e, in_d};
        end
    end

endmodule

// File: doc/page_stream_queue.md
# page_stream_queue

Parametrised stream queue for page boundaries in the TDF stream fabric. Replaces the fixed per-stream page queues with one block that is generic in data width, depth and backpressure slack. It carries the end-of-stream flag alongside data and closes the stream after an end-of-stream token. It sits between an operator's stream port and the inter-page interconnect, on either the input or the output side of a page.

## Interface
Parameters:
- WIDTH, 16, data bits per token (1..64)
- DEPTH, 4, token entries (2..64; need not be a power of two)
- SLACK, 1, tokens the producer may still send after in_b rises (0..DEPTH-1)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- in_d  in  WIDTH  producer data
- in_e  in  1  producer end-of-stream flag, qualified by in_v
- in_v  in  1  producer token valid
- in_b  out  1  backpressure to producer
- out_d  out  WIDTH  head token data
- out_e  out  1  head token end-of-stream flag
- out_v  out  1  head token valid
- out_b  in  1  consumer backpressure; a token is dequeued when out_v=1 and out_b=0
- count  out  clog2(DEPTH+1)  current occupancy
- overflow  out  1  sticky: token arrived while full and not dequeuing
- eos_err  out  1  sticky: token arrived while stream closed

## Operation
- Storage: DEPTH entries of {in_e, in_d}, circular buffer. rd_ptr and wr_ptr wrap from DEPTH-1 to 0.
- State machine with two states, OPEN and CLOSED. Reset state is OPEN.
- OPEN, in_v=1:
  - token enqueued when count<DEPTH, or when count==DEPTH and a dequeue occurs the same cycle;
  - if count==DEPTH and no dequeue: token dropped, overflow<=1;
  - if the accepted token has in_e=1: next state CLOSED.
- CLOSED:
  - in_v=1 tokens are ignored (not enqueued) and set eos_err<=1;
  - transition to OPEN on the cycle the head token with out_e=1 is dequeued.
- The state at the start of a cycle governs the cycle. A token arriving in the same cycle as the EOS dequeue is still ignored.
- in_b = (state==CLOSED) or (count >= DEPTH-SLACK). It is combinational from registers only.
- out_v = (count!=0). out_d/out_e = entry at rd_ptr.
- count update:
  - +1 on enqueue only;
  - -1 on dequeue only;
  - unchanged on both or neither.
- Reset (reset=0 at an edge):
  - ptrs, count, overflow, eos_err <= 0; state <= OPEN;
  - after reset: out_v=0, out_e=0, out_d=0 (head entry cleared), in_b=0 (SLACK<DEPTH);
  - reset mid-stream discards all stored tokens; entry contents other than the head need not be cleared.

## Timing
- Enqueue latency is 1 cycle: a token accepted at edge N is visible on out_v/out_d after edge N. There is no combinational path from in_* to out_*.
- out_b to in_b has no combinational path; in_b changes only after an edge.
- A full queue with simultaneous enqueue and dequeue sustains 1 token/cycle.
- Producer contract: at most SLACK further tokens after the edge where in_b is first seen 1. Violating it triggers overflow, not corruption.
- Empty queue with a dequeue attempt (out_b=0, out_v=0): no effect.

## Test plan
- Reset and fill: WIDTH=16, DEPTH=4, SLACK=1. Send 0x0001..0x0003 on consecutive cycles.
  - Response: in_b=1 after the third token (count=3).
  - Response: with out_b=1 held, a 4th token 0x0004 is accepted and count=4.
- Drain order: from the full state, drop out_b to 0 for 4 cycles.
  - Response: out_d sequence 0x0001..0x0004, then out_v=0, count=0, in_b=0.
- Full with simultaneous enqueue/dequeue: count=4, out_b=0, in_v=1 with 0x00AA each cycle for 8 cycles.
  - Response: count stays 4 and overflow stays 0.
  - Response: a 5th token with out_b=1 sets overflow=1 and count stays 4.
- End-of-stream: send 0x0010, then 0x0011 with in_e=1, then 0x0012.
  - Response: in_b=1 and CLOSED after the EOS token; 0x0012 is dropped and eos_err=1.
  - Response: after the EOS token is dequeued (out_e=1), in_b=0 and a new 0x0013 is accepted.
- Reset mid-operation: count=3, assert reset=0 for one edge.
  - Response: count=0, out_v=0, in_b=0, flags 0.
  - Response: the next token 0x0055 appears on out_d one cycle after acceptance.
- Pointer wrap: DEPTH=3, SLACK=0. Stream 10 tokens 0..9 with out_b toggling every cycle.
  - Response: output order 0..9 intact and no overflow.
